// File: rtl/lte_dw_dfe_trans_pkg.sv
// Shared definitions for the DFE transpose buffer: bandwidth selector codes,
// reader FSM states and the o_xant group-period helper.
package lte_dw_dfe_trans_pkg;

  localparam logic [1:0] MOD_10M = 2'd1;
  localparam logic [1:0] MOD_15M = 2'd2;
  localparam logic [1:0] MOD_20M = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_I    = 2'd1,
    RD_Q    = 2'd2
  } rd_state_e;

  // Number of antenna groups per o_xant period for a given bandwidth.
  function automatic logic [1:0] xant_groups(input logic [1:0] mod_sel);
    logic [1:0] groups;
    case (mod_sel)
      MOD_10M, MOD_15M: groups = 2'd2;
      MOD_20M:          groups = 2'd1;
      default:          groups = 2'd1;
    endcase
    return groups;
  endfunction

endpackage

// File: rtl/lte_dw_dfe_trans_plane_ram.sv
// Simple dual-port RAM for one IQ plane: one write port, one read port with
// a registered, resettable read output.
module lte_dw_dfe_trans_plane_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Storage array, no reset so it maps onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= {W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lte_dw_dfe_trans_inf_xn.sv
// DFE transpose buffer: packed IQ samples in, NUM_ANT I words then NUM_ANT Q words out,
// ping-pong banked. Optional drop counter enabled by LTE_DW_DFE_TRANS_OVF_CNT_EN.
module lte_dw_dfe_trans_inf_xn
  import lte_dw_dfe_trans_pkg::*;
#(
  parameter int NUM_ANT = 8,
  parameter int IQ_W    = 16
) (
  input  logic              sys_clk_491p52,
  input  logic              sys_rst_491p52,
  input  logic [1:0]        i_mod_sel,
  input  logic              i_fram,
  input  logic              i_vld,
  input  logic [2*IQ_W-1:0] i_data,
  output logic              o_vld,
  output logic              o_fram,
  output logic              o_xant,
  output logic [IQ_W-1:0]   o_data,
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
  output logic              o_ovf,
  output logic [15:0]       o_ovf_cnt
`else
  output logic              o_ovf
`endif
);

  localparam int AW = $clog2(NUM_ANT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ANT - 1);

  logic [AW-1:0] r_wr_idx, w_wr_idx, r_rd_idx;
  logic          r_wr_bank, r_rd_bank, r_fram_pend, r_ovf, r_grp_cnt;
  logic [1:0]    r_full, r_bank_fram, w_set, w_full_la, w_rel_mask;
  logic          r_sel_q, r_vld, r_fram_o, r_xant;
  logic          w_frm, w_wr_ok, w_drop, w_last_wr, w_rd_re, w_release, w_grp, w_xant_hit;
  logic [IQ_W-1:0] w_i_rd, w_q_rd;
  rd_state_e     r_state, w_state_nxt;

  // Write-side decode; w_full_la lets the reader chain onto a group completing this cycle.
  always_comb begin
    w_frm     = i_fram & i_vld;
    w_wr_idx  = w_frm ? {AW{1'b0}} : r_wr_idx;
    w_wr_ok   = i_vld & ~r_full[r_wr_bank];
    w_drop    = i_vld & r_full[r_wr_bank];
    w_last_wr = w_wr_ok & (w_wr_idx == LAST_IDX);
    w_set     = 2'b00;
    if (w_last_wr) begin
      w_set[r_wr_bank] = 1'b1;
    end else begin
      w_set = 2'b00;
    end
    w_full_la = r_full | w_set;
  end

  // Writer index/bank, bank-full flags (release applied before set), frame tags, overflow.
  always_ff @(posedge sys_clk_491p52) begin
    if (!sys_rst_491p52) begin
      r_wr_idx    <= {AW{1'b0}};
      r_wr_bank   <= 1'b0;
      r_full      <= 2'b00;
      r_bank_fram <= 2'b00;
      r_fram_pend <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_idx <= w_last_wr ? {AW{1'b0}} : w_wr_idx + AW'(1);
      end else if (w_frm) begin
        r_wr_idx <= {AW{1'b0}};
      end
      if (w_last_wr) begin
        r_wr_bank              <= ~r_wr_bank;
        r_bank_fram[r_wr_bank] <= r_fram_pend;
        r_fram_pend            <= 1'b0;
      end else if (w_frm) begin
        r_fram_pend <= 1'b1;
      end
      r_full <= (r_full & ~w_rel_mask) | w_set;
      if (w_frm) begin
        r_ovf <= w_drop;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Reader next-state and group-period decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_re     = 1'b0;
    w_release   = 1'b0;
    w_rel_mask  = 2'b00;
    case (r_state)
      RD_IDLE: begin
        if (w_full_la[r_rd_bank]) w_state_nxt = RD_I;
        else                      w_state_nxt = RD_IDLE;
      end
      RD_I: begin
        w_rd_re = 1'b1;
        if (r_rd_idx == LAST_IDX) w_state_nxt = RD_Q;
        else                      w_state_nxt = RD_I;
      end
      RD_Q: begin
        w_rd_re = 1'b1;
        if (r_rd_idx == LAST_IDX) begin
          w_release             = 1'b1;
          w_rel_mask[r_rd_bank] = 1'b1;
          w_state_nxt           = w_full_la[~r_rd_bank] ? RD_I : RD_IDLE;
        end else begin
          w_state_nxt = RD_Q;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
    w_grp      = r_bank_fram[r_rd_bank] ? 1'b0 : r_grp_cnt;
    w_xant_hit = (xant_groups(i_mod_sel) == 2'd1) | w_grp;
  end

  // Reader state, read address and registered output strobes.
  always_ff @(posedge sys_clk_491p52) begin
    if (!sys_rst_491p52) begin
      r_state   <= RD_IDLE;
      r_rd_idx  <= {AW{1'b0}};
      r_rd_bank <= 1'b0;
      r_grp_cnt <= 1'b0;
      r_vld     <= 1'b0;
      r_sel_q   <= 1'b0;
      r_fram_o  <= 1'b0;
      r_xant    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_re) begin
        r_rd_idx <= r_rd_idx + AW'(1);
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_grp_cnt <= ~w_grp;
      end
      r_vld    <= w_rd_re;
      r_sel_q  <= (r_state == RD_Q);
      r_fram_o <= (r_state == RD_I) & (r_rd_idx == {AW{1'b0}}) & r_bank_fram[r_rd_bank];
      r_xant   <= w_release & w_xant_hit;
    end
  end

  lte_dw_dfe_trans_plane_ram #(.DEPTH(2*NUM_ANT), .W(IQ_W)) u_i_plane (
    .i_clk   (sys_clk_491p52),
    .i_rst_n (sys_rst_491p52),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata (i_data[2*IQ_W-1:IQ_W]),
    .i_re    (w_rd_re),
    .i_raddr ({r_rd_bank, r_rd_idx}),
    .o_rdata (w_i_rd)
  );

  lte_dw_dfe_trans_plane_ram #(.DEPTH(2*NUM_ANT), .W(IQ_W)) u_q_plane (
    .i_clk   (sys_clk_491p52),
    .i_rst_n (sys_rst_491p52),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata (i_data[IQ_W-1:0]),
    .i_re    (w_rd_re),
    .i_raddr ({r_rd_bank, r_rd_idx}),
    .o_rdata (w_q_rd)
  );

  assign o_vld  = r_vld;
  assign o_fram = r_fram_o;
  assign o_xant = r_xant;
  assign o_data = r_sel_q ? w_q_rd : w_i_rd;
  assign o_ovf  = r_ovf;

`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Saturating count of dropped samples, restarted by each frame header.
  always_ff @(posedge sys_clk_491p52) begin
    if (!sys_rst_491p52) begin
      r_ovf_cnt <= 16'd0;
    end else if (w_frm) begin
      r_ovf_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_lte_dw_dfe_trans_inf_xn.sv
// Directed bench for lte_dw_dfe_trans_inf_xn: an 8-antenna and a 4-antenna instance,
// output words captured per cycle and compared against hand-derived expectations.
module tb_lte_dw_dfe_trans_inf_xn;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        fram;
    logic        xant;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mod_sel;
  logic        fram8, vld8, fram4, vld4;
  logic [31:0] data;
  logic        o_vld8, o_fram8, o_xant8, o_ovf8;
  logic [15:0] o_data8;
  logic        o_vld4, o_fram4, o_xant4, o_ovf4;
  logic [15:0] o_data4;
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
  logic [15:0] o_cnt8, o_cnt4;
`endif

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    last_cyc = 0;
  int    t;
  word_t q8[$];
  word_t q4[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_vld8) q8.push_back('{cyc, o_data8, o_fram8, o_xant8});
    if (o_vld4) q4.push_back('{cyc, o_data4, o_fram4, o_xant4});
  end

  lte_dw_dfe_trans_inf_xn #(.NUM_ANT(8), .IQ_W(16)) u_dut8 (
    .sys_clk_491p52 (clk),
    .sys_rst_491p52 (rst_n),
    .i_mod_sel      (mod_sel),
    .i_fram         (fram8),
    .i_vld          (vld8),
    .i_data         (data),
    .o_vld          (o_vld8),
    .o_fram         (o_fram8),
    .o_xant         (o_xant8),
    .o_data         (o_data8),
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
    .o_ovf          (o_ovf8),
    .o_ovf_cnt      (o_cnt8)
`else
    .o_ovf          (o_ovf8)
`endif
  );

  lte_dw_dfe_trans_inf_xn #(.NUM_ANT(4), .IQ_W(16)) u_dut4 (
    .sys_clk_491p52 (clk),
    .sys_rst_491p52 (rst_n),
    .i_mod_sel      (mod_sel),
    .i_fram         (fram4),
    .i_vld          (vld4),
    .i_data         (data),
    .o_vld          (o_vld4),
    .o_fram         (o_fram4),
    .o_xant         (o_xant4),
    .o_data         (o_data4),
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
    .o_ovf          (o_ovf4),
    .o_ovf_cnt      (o_cnt4)
`else
    .o_ovf          (o_ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One input cycle; sample a carries I=0x1000+a, Q=0x2000+a.
  task automatic step(input logic fr, input logic v, input int a, input logic sel4);
    @(posedge clk);
    #1;
    fram8    = fr & ~sel4;
    vld8     = v & ~sel4;
    fram4    = fr & sel4;
    vld4     = v & sel4;
    data     = {16'h1000 + a[15:0], 16'h2000 + a[15:0]};
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Compare captured words against ngr consecutive groups of n antennas.
  task automatic chk_stream(input int n, input int ngr, input int per, input int t_first, input logic fr0);
    int exp_w;
    exp_w = ngr * 2 * n;
    chk("word_count", q8.size(), exp_w);
    for (int i = 0; i < q8.size() && i < exp_w; i++) begin
      int g, w, a, exp_d;
      g     = i / (2 * n);
      w     = i % (2 * n);
      a     = g * n + ((w < n) ? w : w - n);
      exp_d = ((w < n) ? 32'h1000 : 32'h2000) + a;
      chk("word_cyc", q8[i].cyc, t_first + i);
      chk("word_data", {16'h0000, q8[i].data}, exp_d);
      chk("word_fram", 32'(q8[i].fram), 32'(fr0 && (i == 0)));
      chk("word_xant", 32'(q8[i].xant), 32'((w == 2 * n - 1) && ((g % per) == per - 1)));
    end
    q8.delete();
  endtask

  initial begin
    rst_n = 1'b0; mod_sel = 2'd3;
    fram8 = 1'b0; vld8 = 1'b0; fram4 = 1'b0; vld4 = 1'b0; data = 32'h0;
    idle(3);
    @(negedge clk);
    chk("rst_vld", 32'(o_vld8), 32'h0);
    chk("rst_data", 32'(o_data8), 32'h0);
    chk("rst_fram", 32'(o_fram8), 32'h0);
    chk("rst_xant", 32'(o_xant8), 32'h0);
    chk("rst_ovf", 32'(o_ovf8), 32'h0);
    chk("rst_vld4", 32'(o_vld4), 32'h0);
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
    chk("rst_cnt", 32'(o_cnt8), 32'h0);
`endif
    rst_n = 1'b1;
    idle(2);

    // 1: one group, valid every 2nd cycle, 20M
    for (int a = 0; a < 8; a++) begin
      step(a == 0, 1'b1, a, 1'b0);
      if (a < 7) idle(1);
    end
    t = last_cyc;
    idle(25);
    chk_stream(8, 1, 1, t + 2, 1'b1);

    // 2: 10M, two groups, second completes on the reader's last Q cycle
    mod_sel = 2'd1;
    for (int a = 0; a < 16; a++) begin
      step(a == 0, 1'b1, a, 1'b0);
      if (a == 7) t = last_cyc;
      if (a < 15) idle(1);
    end
    idle(40);
    chk_stream(8, 2, 2, t + 2, 1'b1);

    // 3: back-to-back samples, third group dropped
    mod_sel = 2'd3;
    for (int a = 0; a < 24; a++) begin
      step(a == 0, 1'b1, a, 1'b0);
      if (a == 7) t = last_cyc;
      @(negedge clk);
      if (a == 16) chk("ovf_before_drop", 32'(o_ovf8), 32'h0);
      if (a == 17) chk("ovf_after_drop", 32'(o_ovf8), 32'h1);
    end
    idle(45);
    chk_stream(8, 2, 1, t + 2, 1'b1);
    chk("ovf_sticky", 32'(o_ovf8), 32'h1);
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
    chk("ovf_cnt", 32'(o_cnt8), 32'd8);
`endif

    // 4: partial group discarded by a new frame header
    for (int a = 0; a < 5; a++) step(a == 0, 1'b1, 32'h80 + a, 1'b0);
    idle(3);
    for (int a = 0; a < 8; a++) step(a == 0, 1'b1, a, 1'b0);
    t = last_cyc;
    idle(25);
    chk_stream(8, 1, 1, t + 2, 1'b1);
    chk("ovf_cleared", 32'(o_ovf8), 32'h0);
`ifdef LTE_DW_DFE_TRANS_OVF_CNT_EN
    chk("ovf_cnt_cleared", 32'(o_cnt8), 32'h0);
`endif

    // 5: reset while reading the Q plane
    for (int a = 0; a < 8; a++) step(a == 0, 1'b1, a, 1'b0);
    idle(12);
    @(negedge clk);
    chk("t5_vld_in_rdq", 32'(o_vld8), 32'h1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_vld", 32'(o_vld8), 32'h0);
    chk("t5_rst_data", 32'(o_data8), 32'h0);
    chk("t5_rst_fram", 32'(o_fram8), 32'h0);
    chk("t5_rst_xant", 32'(o_xant8), 32'h0);
    chk("t5_rst_ovf", 32'(o_ovf8), 32'h0);
    q8.delete();
    for (int a = 0; a < 7; a++) step(1'b0, 1'b1, a, 1'b0);
    idle(10);
    chk("t5_no_partial_out", q8.size(), 0);
    step(1'b0, 1'b1, 7, 1'b0);
    t = last_cyc;
    idle(25);
    chk_stream(8, 1, 1, t + 2, 1'b0);

    // 6: four-antenna instance
    for (int a = 0; a < 4; a++) step(a == 0, 1'b1, a, 1'b1);
    t = last_cyc;
    idle(15);
    q8.delete();
    q8 = q4;
    chk_stream(4, 1, 1, t + 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
